// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
//   PRESSED / RELEASED : normalised level encoding (1 = pressed)
//   clog2_max(a, b)    : counter width able to hold max(a, b)
package debounce_pkg;

  localparam logic PRESSED  = 1'b1;
  localparam logic RELEASED = 1'b0;

  // Bits needed to count from 0 up to max(a, b) without wrapping.
  function automatic int unsigned clog2_max(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return 32'($clog2(m + 32'd1));
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Pin/event bundle between board pins, the debouncer and the control FSMs.
//   but_in      : raw asynchronous pins, one bit per channel
//   but_level   : debounced level, 1 = pressed
//   but_press   : one-cycle strobe on accepted press
//   but_release : one-cycle strobe on accepted release
//   long_press  : one-cycle strobe after a long accepted press
// master drives the pins and consumes events; slave is the debouncer.
interface debounce_multi_if #(
  parameter int unsigned N_CH = 4
);

  logic [N_CH-1:0] but_in;
  logic [N_CH-1:0] but_level;
  logic [N_CH-1:0] but_press;
  logic [N_CH-1:0] but_release;
  logic [N_CH-1:0] long_press;

  modport master (
    output but_in,
    input  but_level, but_press, but_release, long_press
  );

  modport slave (
    input  but_in,
    output but_level, but_press, but_release, long_press
  );

endinterface

// File: rtl/debounce_chan.sv
// Single-channel debouncer: 2-flop synchroniser, polarity normalisation,
// symmetric settle counter, debounced level, press/release strobes and an
// optional one-shot long-press strobe.
//   hwclk, rst  : clock, asynchronous active-high reset
//   pin         : raw asynchronous pin
//   level       : debounced level, 1 = pressed
//   press, rel  : one-cycle strobes on accepted press / release
//   long_press  : one-cycle strobe after HOLD_PERIOD cycles of accepted press
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_PERIOD = 120000,
  parameter int unsigned HOLD_PERIOD     = 0,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic hwclk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_press
);

  localparam int unsigned      CNT_W       = clog2_max(DEBOUNCE_PERIOD, HOLD_PERIOD);
  localparam logic             IDLE_PIN    = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_PERIOD - 1);

  logic             s1;
  logic             s2;
  logic             norm;
  logic             settle_done;
  logic [CNT_W-1:0] cnt;

  // Synchroniser; resets to the inactive pin level so reset reads as released.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      s1 <= IDLE_PIN;
      s2 <= IDLE_PIN;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  assign norm        = ACTIVE_LOW ? ~s2 : s2;
  // Last disagreeing cycle of a settle window: the level flips on this edge.
  assign settle_done = (norm != level) && (cnt == SETTLE_LAST);

  // Settle counter, level and edge strobes.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= RELEASED;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (norm == level) begin
        cnt <= '0;
      end else if (cnt == SETTLE_LAST) begin
        cnt   <= '0;
        level <= norm;
        press <= (norm == PRESSED);
        rel   <= (norm == RELEASED);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  if (HOLD_PERIOD > 0) begin : g_hold
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_PERIOD - 1);

    logic [CNT_W-1:0] hcnt;
    logic             fired;

    // Hold timer; a release accepted on the expiry edge suppresses the strobe.
    always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
        hcnt       <= '0;
        fired      <= 1'b0;
        long_press <= 1'b0;
      end else begin
        long_press <= 1'b0;
        if ((level == RELEASED) || settle_done) begin
          hcnt  <= '0;
          fired <= 1'b0;
        end else if (!fired) begin
          if (hcnt == HOLD_LAST) begin
            long_press <= 1'b1;
            fired      <= 1'b1;
          end else begin
            hcnt <= hcnt + CNT_W'(1);
          end
        end
      end
    end
  end else begin : g_no_hold
    assign long_press = 1'b0;
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button / switch debouncer; channels are fully independent.
//   hwclk, rst : clock, asynchronous active-high reset
//   bus        : slave side of debounce_multi_if (raw pins in, debounced
//                level and press/release/long-press strobes out)
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_PERIOD = 120000,
  parameter int unsigned HOLD_PERIOD     = 0,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic            hwclk,
  input  logic            rst,
  debounce_multi_if.slave bus
);

  logic [N_CH-1:0] level_v;
  logic [N_CH-1:0] press_v;
  logic [N_CH-1:0] rel_v;
  logic [N_CH-1:0] long_v;

  // One debouncer per pin.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_PERIOD (DEBOUNCE_PERIOD),
      .HOLD_PERIOD     (HOLD_PERIOD),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .hwclk      (hwclk),
      .rst        (rst),
      .pin        (bus.but_in[i]),
      .level      (level_v[i]),
      .press      (press_v[i]),
      .rel        (rel_v[i]),
      .long_press (long_v[i])
    );
  end

  assign bus.but_level   = level_v;
  assign bus.but_press   = press_v;
  assign bus.but_release = rel_v;
  assign bus.long_press  = long_v;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios with literal
// latency expectations plus randomized pin activity, all compared every cycle
// against a window-based behavioural model.
module tb_debounce_multi;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int H  = 20;
  localparam bit AL = 1'b1;

  localparam int K_LEVEL = 0;
  localparam int K_PRESS = 1;
  localparam int K_REL   = 2;
  localparam int K_LONG  = 3;

  logic hwclk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  debounce_multi_if #(.N_CH(N)) bus ();

  debounce_multi #(
    .N_CH            (N),
    .DEBOUNCE_PERIOD (D),
    .HOLD_PERIOD     (H),
    .ACTIVE_LOW      (AL)
  ) dut (
    .hwclk (hwclk),
    .rst   (rst),
    .bus   (bus)
  );

  initial begin
    hwclk = 1'b0;
    forever #5 hwclk = ~hwclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A channel flips when the last D synchronised samples all disagree with
  // the current level and at least D edges have passed since the last flip
  // (or reset). Long-press fires on the H-th edge after the press edge.
  logic [N-1:0] m_lvl   = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel   = '0;
  logic [N-1:0] m_long  = '0;
  logic [N-1:0] pipe0   = '1;
  logic [N-1:0] pipe1   = '1;
  bit           win   [N][D];
  int           since [N];
  int           held  [N];
  bit           fired [N];

  initial begin
    forever begin
      @(posedge hwclk or posedge rst);
      if (rst) begin
        m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
        pipe0 = AL ? '1 : '0;
        pipe1 = AL ? '1 : '0;
        for (int c = 0; c < N; c++) begin
          since[c] = 0; held[c] = 0; fired[c] = 1'b0;
          for (int k = 0; k < D; k++) win[c][k] = 1'b0;
        end
      end else begin
        for (int c = 0; c < N; c++) begin
          bit n;
          bit all_diff;
          bit acc;
          n = AL ? ~pipe1[c] : pipe1[c];
          pipe1[c] = pipe0[c];
          pipe0[c] = bus.but_in[c];
          for (int k = D - 1; k > 0; k--) win[c][k] = win[c][k-1];
          win[c][0] = n;
          since[c]++;
          all_diff = 1'b1;
          for (int k = 0; k < D; k++) if (win[c][k] == m_lvl[c]) all_diff = 1'b0;
          acc = (since[c] >= D) && all_diff;
          m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0;
          if (m_lvl[c] && !acc) begin
            if (!fired[c]) begin
              held[c]++;
              if (held[c] == H) begin
                m_long[c] = 1'b1;
                fired[c]  = 1'b1;
              end
            end
          end else begin
            held[c]  = 0;
            fired[c] = 1'b0;
          end
          if (acc) begin
            m_lvl[c]   = ~m_lvl[c];
            m_press[c] = m_lvl[c];
            m_rel[c]   = ~m_lvl[c];
            since[c]   = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge hwclk);
      if (cmp_en) begin
        check("model_level",   32'(bus.but_level),   32'(m_lvl));
        check("model_press",   32'(bus.but_press),   32'(m_press));
        check("model_release", 32'(bus.but_release), 32'(m_rel));
        check("model_long",    32'(bus.long_press),  32'(m_long));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [N-1:0] get_vec(input int kind);
    case (kind)
      K_LEVEL: return bus.but_level;
      K_PRESS: return bus.but_press;
      K_REL:   return bus.but_release;
      default: return bus.long_press;
    endcase
  endfunction

  // Called at a negedge: pins change 1 time unit later.
  task automatic set_pins(input logic [N-1:0] v);
    #1;
    bus.but_in = v;
  endtask

  // Cycles until every masked bit of the chosen output is high; -1 on timeout.
  task automatic wait_vec(input int kind, input logic [N-1:0] mask, input int maxc,
                          output int lat);
    lat = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge hwclk);
      if ((get_vec(kind) & mask) == mask) begin
        lat = k;
        break;
      end
    end
  endtask

  // Drive pins for n cycles, counting cycles where output bit ch is high.
  task automatic drive_for(input logic [N-1:0] v, input int n, input int kind,
                           input int ch, inout int hits);
    set_pins(v);
    for (int k = 0; k < n; k++) begin
      @(negedge hwclk);
      if (get_vec(kind)[ch]) hits++;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int           lat;
    int           hits;
    int           p0;
    int           r3;
    logic [N-1:0] pins;
    int           run [N];

    rst = 1'b1;
    bus.but_in = '0;

    // 1. Reset with all pins pressed, then re-acceptance of all channels.
    @(negedge hwclk);
    cmp_en = 1'b1;
    repeat (2) @(negedge hwclk);
    check("t1_rst_outputs", 32'({bus.but_level, bus.but_press, bus.but_release, bus.long_press}), 32'd0);
    #1 rst = 1'b0;
    wait_vec(K_PRESS, 4'b1111, 20, lat);
    check("t1_press_latency", 32'(lat), 32'd10);
    check("t1_level", 32'(bus.but_level), 32'hF);
    set_pins(4'b1111);
    wait_vec(K_REL, 4'b1111, 20, lat);
    check("t1_release_latency", 32'(lat), 32'd10);
    repeat (3) @(negedge hwclk);

    // 2. Clean press on ch0.
    set_pins(4'b1110);
    wait_vec(K_PRESS, 4'b0001, 20, lat);
    check("t2_press_latency", 32'(lat), 32'd10);
    check("t2_level", 32'(bus.but_level), 32'b0001);

    // 3. Glitch rejection on ch1, then a real press.
    hits = 0;
    drive_for(4'b1100, 7, K_LEVEL, 1, hits);
    drive_for(4'b1110, 1, K_LEVEL, 1, hits);
    drive_for(4'b1100, 7, K_LEVEL, 1, hits);
    drive_for(4'b1110, 12, K_LEVEL, 1, hits);
    check("t3_glitch_level_hits", 32'(hits), 32'd0);
    set_pins(4'b1100);
    wait_vec(K_PRESS, 4'b0010, 20, lat);
    check("t3_press_latency", 32'(lat), 32'd10);

    // 4. Long press on ch2, single strobe, then release.
    set_pins(4'b1000);
    wait_vec(K_PRESS, 4'b0100, 20, lat);
    check("t4_press_latency", 32'(lat), 32'd10);
    wait_vec(K_LONG, 4'b0100, 30, lat);
    check("t4_long_latency", 32'(lat), 32'd20);
    hits = 0;
    drive_for(4'b1000, 20, K_LONG, 2, hits);
    check("t4_long_repeat", 32'(hits), 32'd0);
    set_pins(4'b1100);
    wait_vec(K_REL, 4'b0100, 20, lat);
    check("t4_release_latency", 32'(lat), 32'd10);

    // 5. ch0 press and ch3 release on the same edge.
    hits = 0;
    drive_for(4'b0101, 15, K_PRESS, 3, hits);
    check("t5_ch3_pre_press", 32'(hits), 32'd1);
    set_pins(4'b1100);
    p0 = -1;
    r3 = -1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge hwclk);
      if (bus.but_press[0] && p0 < 0) p0 = k;
      if (bus.but_release[3] && r3 < 0) r3 = k;
    end
    check("t5_ch0_press", 32'(p0), 32'd10);
    check("t5_ch3_release", 32'(r3), 32'd10);

    // 6. Reset in the middle of a hold on ch2.
    set_pins(4'b1000);
    wait_vec(K_PRESS, 4'b0100, 20, lat);
    check("t6_press_latency", 32'(lat), 32'd10);
    repeat (12) @(negedge hwclk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_outputs", 32'({bus.but_level, bus.but_press, bus.but_release, bus.long_press}), 32'd0);
    repeat (2) @(negedge hwclk);
    #1 rst = 1'b0;
    wait_vec(K_PRESS, 4'b0100, 20, lat);
    check("t6_repress_latency", 32'(lat), 32'd10);
    wait_vec(K_LONG, 4'b0100, 30, lat);
    check("t6_fresh_long_latency", 32'(lat), 32'd20);

    // Randomized pin activity with occasional reset pulses.
    pins = bus.but_in;
    for (int c = 0; c < N; c++) run[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      #1;
      for (int c = 0; c < N; c++) begin
        if (run[c] == 0) begin
          pins[c] = ~pins[c];
          run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                : int'($urandom_range(1, 12));
        end else begin
          run[c]--;
        end
      end
      bus.but_in = pins;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      @(negedge hwclk);
    end
    #1 rst = 1'b0;
    repeat (5) @(negedge hwclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
